vector_sched: RTL and testbench

VECTOR_SCHED -- requirements
Module: vector_sched

---
 rtl/vector_sched_pkg.sv | 17 +
 rtl/vector_sched_vector.sv | 20 ++
 rtl/vector_sched.sv | 129 ++++++++++++
 tb/tb_vector_sched.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vector_sched_pkg.sv
// Shared definitions for the vector_sched slice: opcodes, FSM state type, default operand width.
package vector_sched_pkg;

  localparam int unsigned W_DEFAULT = 4;

  localparam logic [1:0] OP_BOR = 2'd0;
  localparam logic [1:0] OP_LOR = 2'd1;
  localparam logic [1:0] OP_ROR = 2'd2;
  localparam logic [1:0] OP_NOT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } vs_state_e;

endpackage

// File: rtl/vector_sched_vector.sv
// vector: combinational operator bank producing every opcode's result in parallel.
module vector
  import vector_sched_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   bor,
  output logic           lor,
  output logic [1:0]     ror,
  output logic [2*W-1:0] bnot
);

  assign bor  = a | b;
  assign lor  = (|a) || (|b);
  assign ror  = {|b, |a};
  assign bnot = {~a, ~b};

endmodule

// File: rtl/vector_sched.sv
// vector_sched: two-requester round-robin scheduler for the vector operator bank.
// Optional grant statistics are enabled with `define VECTOR_SCHED_STATS_EN.
module vector_sched
  import vector_sched_pkg::*;
#(
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic [1:0]     req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic [1:0]     req1_op,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_data
`ifdef VECTOR_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  vs_state_e      state_q, state_d;
  logic           ptr_q;
  logic           grant;
  logic           accept;
  logic [W-1:0]   a_q, b_q;
  logic [1:0]     op_q;
  logic           id_q;

  logic [W-1:0]   v_bor;
  logic           v_lor;
  logic [1:0]     v_ror;
  logic [2*W-1:0] v_bnot;
  logic [2*W-1:0] result;

  vector #(.W(W)) u_vector (
    .a    (a_q),
    .b    (b_q),
    .bor  (v_bor),
    .lor  (v_lor),
    .ror  (v_ror),
    .bnot (v_bnot)
  );

  always_comb begin
    result = '0;
    unique case (op_q)
      OP_BOR:  result[W-1:0] = v_bor;
      OP_LOR:  result[0]     = v_lor;
      OP_ROR:  result[1:0]   = v_ror;
      OP_NOT:  result        = v_bnot;
      default: result        = '0;
    endcase
  end

  // Pointer only arbitrates a tie; a lone valid requester always wins.
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant      = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    unique case (state_q)
      ST_IDLE: begin
        req0_ready = !rst && req0_valid && !grant;
        req1_ready = !rst && req1_valid && grant;
        if (req0_ready || req1_ready) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept    = req0_ready || req1_ready;
  assign rsp_valid = (state_q == ST_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      id_q     <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= grant ? req1_a  : req0_a;
        b_q   <= grant ? req1_b  : req0_b;
        op_q  <= grant ? req1_op : req0_op;
        id_q  <= grant;
        ptr_q <= !grant;
      end
      if (state_q == ST_EXEC) begin
        rsp_data <= result;
        rsp_id   <= id_q;
      end
    end
  end

`ifdef VECTOR_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req1_ready && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vector_sched.sv
// Self-checking bench for vector_sched: directed scenarios plus randomized traffic vs a transaction model.
module tb_vector_sched;

  localparam int unsigned W     = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned MASK  = (1 << W) - 1;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req0_valid = 1'b0, req1_valid = 1'b0;
  logic           req0_ready, req1_ready;
  logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]     req0_op = '0, req1_op = '0;
  logic           rsp_valid, rsp_id;
  logic           rsp_ready = 1'b0;
  logic [2*W-1:0] rsp_data;
`ifdef VECTOR_SCHED_STATS_EN
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

  vector_sched #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
`ifdef VECTOR_SCHED_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: busy/response flags, tie pointer, latched job, grant tallies.
  bit          m_busy, m_resp, m_ptr, m_id, m_jid;
  int unsigned m_data, m_ja, m_jb, m_jop, m_c0, m_c1;

  function automatic int unsigned ref_op(int unsigned op, int unsigned a, int unsigned b);
    case (op)
      0:       return a | b;
      1:       return (a != 0 || b != 0) ? 1 : 0;
      2:       return ((b != 0) ? 2 : 0) + ((a != 0) ? 1 : 0);
      default: return (((~a) & MASK) << W) | ((~b) & MASK);
    endcase
  endfunction

  task automatic tick();
    bit g, acc0, acc1;
    #2;
    g    = (req0_valid && req1_valid) ? m_ptr : req1_valid;
    acc0 = !rst && !m_busy && !m_resp && req0_valid && !g;
    acc1 = !rst && !m_busy && !m_resp && req1_valid && g;
    check("req0_ready", req0_ready, acc0);
    check("req1_ready", req1_ready, acc1);
    check("rsp_valid", rsp_valid, m_resp);
    check("rsp_id", rsp_id, m_id);
    check("rsp_data", rsp_data, m_data);
`ifdef VECTOR_SCHED_STATS_EN
    check("grant_cnt0", grant_cnt0, m_c0);
    check("grant_cnt1", grant_cnt1, m_c1);
`endif
    @(posedge clk);
    #1;
    if (rst) begin
      m_busy = 0; m_resp = 0; m_ptr = 0; m_id = 0; m_data = 0; m_c0 = 0; m_c1 = 0;
    end else if (m_resp) begin
      if (rsp_ready) m_resp = 0;
    end else if (m_busy) begin
      m_busy = 0;
      m_resp = 1;
      m_data = ref_op(m_jop, m_ja, m_jb);
      m_id   = m_jid;
    end else if (acc0 || acc1) begin
      m_ja   = acc1 ? req1_a  : req0_a;
      m_jb   = acc1 ? req1_b  : req0_b;
      m_jop  = acc1 ? req1_op : req0_op;
      m_jid  = acc1;
      m_ptr  = acc0;
      m_busy = 1;
      if (acc0 && m_c0 < CMAX) m_c0++;
      if (acc1 && m_c1 < CMAX) m_c1++;
    end
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();

    // Single req0 OR operation and its latency.
    rst = 1'b0; req0_valid = 1'b1; req0_a = 4'b0101; req0_b = 4'b0011; req0_op = 2'd0;
    #2 check("d1_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    #1;
    check("d1_valid", rsp_valid, 1);
    check("d1_id", rsp_id, 0);
    check("d1_data", rsp_data, 8'b00000111);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1 check("d1_drop", rsp_valid, 0);

    // Logical OR from req1.
    for (int i = 0; i < 2; i++) begin
      req1_valid = 1'b1; req1_a = (i == 0) ? 4'b0000 : 4'b0101; req1_b = 4'b0000; req1_op = 2'd1;
      tick();
      req1_valid = 1'b0;
      tick();
      #1;
      check("d2_id", rsp_id, 1);
      check("d2_data", rsp_data, (i == 0) ? 8'b00000000 : 8'b00000001);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end

    // Round-robin alternation from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'b0101; req0_b = 4'b0000; req0_op = 2'd2;
    req1_valid = 1'b1; req1_a = 4'b0101; req1_b = 4'b0000; req1_op = 2'd2;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("d3_ready0", req0_ready, (k % 2) == 0);
      check("d3_ready1", req1_ready, (k % 2) == 1);
      tick();
      tick();
      #1;
      check("d3_id", rsp_id, k % 2);
      check("d3_data", rsp_data, 8'b00000001);
      tick();
    end
    req1_valid = 1'b0;

    // Held response under backpressure.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'b1111; req0_b = 4'b1111; req0_op = 2'd3;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      check("d4_valid", rsp_valid, 1);
      check("d4_data", rsp_data, 8'b00000000);
      check("d4_noready", req1_ready, 0);
      tick();
    end
    req1_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1 check("d4_clear", rsp_valid, 0);

    // Reset during EXEC discards the job and restores req0 priority.
    req0_valid = 1'b1; req0_a = 4'b0110; req0_b = 4'b0001; req0_op = 2'd0;
    tick();
    req0_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("d5_valid", rsp_valid, 0);
    check("d5_data", rsp_data, 0);
    check("d5_id", rsp_id, 0);
    check("d5_ready0", req0_ready, 0);
    check("d5_ready1", req1_ready, 0);
`ifdef VECTOR_SCHED_STATS_EN
    check("d5_cnt0", grant_cnt0, 0);
    check("d5_cnt1", grant_cnt1, 0);
`endif
    tick();
    check("d5_still_idle", rsp_valid, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("d5_ptr0_ready0", req0_ready, 1);
    check("d5_ptr0_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    tick();
    rsp_ready = 1'b0;

`ifdef VECTOR_SCHED_STATS_EN
    // Saturation of the req0 grant counter.
    rst = 1'b1;
    tick();
    rst = 1'b0; req0_valid = 1'b1; rsp_ready = 1'b1;
    repeat (900) tick();
    check("d6_cnt0_sat", grant_cnt0, 255);
    check("d6_cnt1", grant_cnt1, 0);
    req0_valid = 1'b0;
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      req0_valid = $urandom_range(0, 2) != 0;
      req1_valid = $urandom_range(0, 2) != 0;
      req0_a     = W'($urandom);
      req0_b     = W'($urandom);
      req0_op    = 2'($urandom);
      req1_a     = W'($urandom);
      req1_b     = W'($urandom);
      req1_op    = 2'($urandom);
      rsp_ready  = $urandom_range(0, 2) != 0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
